// File: rtl/dma_ram_stream_writer.sv
// Packs a byte stream big-endian into 32-bit words and writes them to RAM port B; frame ends on s_last_i, RAM stall or reset.
// Latency: a completed word is written the cycle after its 4th byte; s_ready_o is high only in RECV and drops after a stall is seen.
module dma_ram_stream_writer #(
    parameter int ADDR_WIDTH = 13,
    parameter int MAX_WORDS  = 2048
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-3:0] cfg_base_i,
    input  logic [ADDR_WIDTH-3:0] cfg_len_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] byte_cnt_o,
    input  logic [7:0]            s_data_i,
    input  logic                  s_valid_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic [ADDR_WIDTH-3:0] rawp_adr_o,
    output logic [31:0]           rawp_dat_o,
    output logic                  rawp_we_o,
    input  logic                  rawp_stall_i
);

    localparam int WA = ADDR_WIDTH - 2;

    if (MAX_WORDS > (1 << WA)) begin : g_cfg_chk
        $error("MAX_WORDS exceeds the port B word address space");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_FLUSH,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WA-1:0]         base_q, base_d;
    logic [WA-1:0]         len_q, len_d;
    logic [WA-1:0]         word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           pack_q, pack_d;
    logic [ADDR_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic                  chk_q, chk_d;
    logic [WA-1:0]         adr_q, adr_d;
    logic [31:0]           dat_q, dat_d;

    logic        accept;
    logic        word_end;
    logic        full;
    logic        stall_hit;
    logic [31:0] merged;

    assign s_ready_o  = (state_q == S_RECV);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign overflow_o = ovf_q;
    assign err_o      = err_q;
    assign byte_cnt_o = byte_cnt_q;
    assign rawp_adr_o = adr_q;
    assign rawp_dat_o = dat_q;
    assign rawp_we_o  = we_q;

    assign accept    = s_ready_o & s_valid_i;
    assign word_end  = (byte_idx_q == 2'd3) | s_last_i;
    assign full      = (word_idx_q == len_q);
    // chk_q marks the cycle in which the RAM reports on the previous cycle's write
    assign stall_hit = chk_q & rawp_stall_i;
    assign merged    = pack_q | ({s_data_i, 24'h000000} >> {byte_idx_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        we_d       = 1'b0;
        chk_d      = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d     = cfg_base_i;
                    len_d      = cfg_len_i;
                    word_idx_d = '0;
                    byte_idx_d = 2'd0;
                    pack_d     = '0;
                    byte_cnt_d = '0;
                    ovf_d      = 1'b0;
                    err_d      = 1'b0;
                    chk_d      = 1'b0;
                    state_d    = S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    if (byte_cnt_q != {ADDR_WIDTH{1'b1}}) begin
                        byte_cnt_d = byte_cnt_q + ADDR_WIDTH'(1);
                    end
                    if (word_end) begin
                        pack_d     = '0;
                        byte_idx_d = 2'd0;
                        if (full) begin
                            ovf_d = 1'b1;
                        end else if (!stall_hit) begin
                            we_d       = 1'b1;
                            adr_d      = base_q + word_idx_q;
                            dat_d      = merged;
                            word_idx_d = word_idx_q + WA'(1);
                        end
                    end else begin
                        pack_d     = merged;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                    if (s_last_i) begin
                        state_d = S_FLUSH;
                    end
                end
                // A stall aborts the frame even if this cycle also carried s_last_i
                if (stall_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_FLUSH: begin
                if (stall_hit) begin
                    err_d = 1'b1;
                end
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (stall_hit) begin
                    err_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            pack_q     <= '0;
            byte_cnt_q <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            chk_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            pack_q     <= pack_d;
            byte_cnt_q <= byte_cnt_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            we_q       <= we_d;
            chk_q      <= chk_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

endmodule

// File: tb/tb_dma_ram_stream_writer.sv
// Directed frames for dma_ram_stream_writer; expected RAM writes and done status are queued
// by the stimulus and popped by a negedge monitor whenever the DUT writes or signals done.
module tb_dma_ram_stream_writer;

    localparam int AW = 14;
    localparam int WA = AW - 2;
    localparam int MW = 2048;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [WA-1:0] cfg_base_i;
    logic [WA-1:0] cfg_len_i;
    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;
    logic          err_o;
    logic [AW-1:0] byte_cnt_o;
    logic [7:0]    s_data_i;
    logic          s_valid_i;
    logic          s_last_i;
    logic          s_ready_o;
    logic [WA-1:0] rawp_adr_o;
    logic [31:0]   rawp_dat_o;
    logic          rawp_we_o;
    logic          rawp_stall_i;

    dma_ram_stream_writer #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_base_i   (cfg_base_i),
        .cfg_len_i    (cfg_len_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o),
        .err_o        (err_o),
        .byte_cnt_o   (byte_cnt_o),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_last_i     (s_last_i),
        .s_ready_o    (s_ready_o),
        .rawp_adr_o   (rawp_adr_o),
        .rawp_dat_o   (rawp_dat_o),
        .rawp_we_o    (rawp_we_o),
        .rawp_stall_i (rawp_stall_i)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: out-of-range flag registered one cycle after the write address
    logic stall_en = 1'b1;
    logic stall_q  = 1'b0;
    always @(posedge clk_i) begin
        stall_q <= stall_en && rawp_we_o && (int'(rawp_adr_o) >= MW);
    end
    assign rawp_stall_i = stall_q;

    typedef struct {
        logic [WA-1:0] adr;
        logic [31:0]   dat;
    } wr_t;

    typedef struct {
        logic [AW-1:0] cnt;
        logic          ovf;
        logic          err;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    done_seen   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [WA-1:0] adr, input logic [31:0] dat);
        wr_t w;
        w.adr = adr;
        w.dat = dat;
        exp_wr.push_back(w);
    endtask

    task automatic push_done(input int cnt, input logic ovf, input logic err);
        done_t d;
        d.cnt = AW'(cnt);
        d.ovf = ovf;
        d.err = err;
        exp_done.push_back(d);
    endtask

    always @(negedge clk_i) begin
        if (rawp_we_o) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write_adr", 32'(rawp_adr_o), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("write_adr", 32'(rawp_adr_o), 32'(w.adr));
                check("write_dat", rawp_dat_o, w.dat);
            end
        end
        if (done_o) begin
            done_seen++;
            if (exp_done.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                done_t d;
                d = exp_done.pop_front();
                check("done_byte_cnt", 32'(byte_cnt_o), 32'(d.cnt));
                check("done_overflow", 32'(overflow_o), 32'(d.ovf));
                check("done_err", 32'(err_o), 32'(d.err));
                check("done_busy", 32'(busy_o), 32'd1);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic start_frame(input logic [WA-1:0] base, input logic [WA-1:0] len);
        cfg_base_i = base;
        cfg_len_i  = len;
        start_i    = 1'b1;
        cycles(1);
        start_i    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic last);
        logic acc;
        int   tries;
        s_valid_i = 1'b1;
        s_data_i  = data;
        s_last_i  = last;
        tries     = 0;
        do begin
            acc = s_ready_o;
            cycles(1);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            check("send_timeout", 32'(data), 32'hFFFF_FFFF);
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start_cnt;
        int n;
        start_cnt = done_seen;
        n = 0;
        while (done_seen == start_cnt && n < 300) begin
            cycles(1);
            n++;
        end
        if (done_seen == start_cnt) begin
            check({name, "_done_timeout"}, 32'(done_seen), 32'(start_cnt + 1));
        end
        cycles(2);
        check({name, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
        check({name, "_busy_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_i      = 1'b1;
        cfg_base_i = '0;
        cfg_len_i  = '0;
        start_i    = 1'b0;
        s_data_i   = 8'h00;
        s_valid_i  = 1'b0;
        s_last_i   = 1'b0;
        cycles(3);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(s_ready_o), 32'd0);
        check("rst_we", 32'(rawp_we_o), 32'd0);
        check("rst_cnt", 32'(byte_cnt_o), 32'd0);
        rst_i = 1'b0;
        cycles(2);

        // Two full words back-to-back
        push_wr(12'h010, 32'h0102_0304);
        push_wr(12'h011, 32'h0506_0708);
        push_done(8, 1'b0, 1'b0);
        start_frame(12'h010, 12'd4);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_done("full_words");

        // Partial trailing word zero-filled
        push_wr(12'h020, 32'hAABB_CCDD);
        push_wr(12'h021, 32'hEE00_0000);
        push_done(5, 1'b0, 1'b0);
        start_frame(12'h020, 12'd4);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b1);
        wait_done("partial");

        // Capacity of one word, nine bytes
        push_wr(12'h000, 32'h1112_1314);
        push_done(9, 1'b1, 1'b0);
        start_frame(12'h000, 12'd1);
        for (int i = 0; i < 9; i++) send_byte(8'(8'h11 + i), i == 8);
        wait_done("overflow");

        // Second word lands out of range: abort without s_last_i
        push_wr(12'(MW - 1), 32'h2122_2324);
        push_wr(12'(MW), 32'h2526_2728);
        push_done(8, 1'b0, 1'b1);
        start_frame(12'(MW - 1), 12'd4);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + i), 1'b0);
        wait_done("stall");
        check("stall_ready_low", 32'(s_ready_o), 32'd0);
        check("stall_err_hold", 32'(err_o), 32'd1);

        // Reset mid-frame after six bytes
        push_wr(12'h040, 32'h3132_3334);
        start_frame(12'h040, 12'd4);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h31 + i), 1'b0);
        rst_i = 1'b1;
        cycles(1);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check("mid_rst_ready", 32'(s_ready_o), 32'd0);
        check("mid_rst_we", 32'(rawp_we_o), 32'd0);
        check("mid_rst_cnt", 32'(byte_cnt_o), 32'd0);
        check("mid_rst_adr", 32'(rawp_adr_o), 32'd0);
        check("mid_rst_dat", rawp_dat_o, 32'd0);
        check("mid_rst_flags", {30'd0, overflow_o, err_o}, 32'd0);
        rst_i = 1'b0;
        cycles(4);
        push_wr(12'h040, 32'h4142_4344);
        push_done(4, 1'b0, 1'b0);
        start_frame(12'h040, 12'd4);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h41 + i), i == 3);
        wait_done("after_rst");

        // Valid gaps plus a start pulse that must be ignored while busy
        push_wr(12'h050, 32'h5152_5354);
        push_wr(12'h051, 32'h5556_5700);
        push_done(7, 1'b0, 1'b0);
        start_frame(12'h050, 12'd4);
        send_byte(8'h51, 1'b0);
        send_byte(8'h52, 1'b0);
        cfg_base_i = 12'h300;
        cfg_len_i  = 12'd0;
        start_i    = 1'b1;
        cycles(1);
        start_i    = 1'b0;
        send_byte(8'h53, 1'b0);
        cycles(3);
        send_byte(8'h54, 1'b0);
        send_byte(8'h55, 1'b0);
        cycles(2);
        send_byte(8'h56, 1'b0);
        send_byte(8'h57, 1'b1);
        wait_done("gaps");

        // Word address wraps past the top of the address space
        stall_en = 1'b0;
        push_wr(12'hFFF, 32'h6162_6364);
        push_wr(12'h000, 32'h6566_6768);
        push_done(8, 1'b0, 1'b0);
        start_frame(12'hFFF, 12'd3);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h61 + i), i == 7);
        wait_done("wrap");
        stall_en = 1'b1;

        // Zero capacity: bytes counted, nothing written
        push_done(2, 1'b1, 1'b0);
        start_frame(12'h070, 12'd0);
        send_byte(8'h71, 1'b0);
        send_byte(8'h72, 1'b1);
        wait_done("zero_len");
        check("zero_len_done_drained", 32'(exp_done.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
